// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg : shared FSM state type and length-mask helper for seq_detector_cfg
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package seq_det_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam int MASK_W = 32;

  // Low `len` bits set; patterns wider than MASK_W are never requested.
  function automatic logic [MASK_W-1:0] len_mask(input logic [MASK_W-1:0] len);
    if (len >= MASK_W) return '1;
    return (MASK_W'(1) << len) - MASK_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : up-counter with synchronous clear that holds at all-ones
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/seq_detector_cfg.sv
// ---------------------------------------------------------------------------
// seq_detector_cfg : runtime-programmable serial pattern detector with
//                    overlap control and saturating match counter
// Revision         : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seq_detector_cfg #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  output logic               cfg_err_o,
  input  logic               clear_i,
  input  logic               in_valid_i,
  input  logic               in_bit_i,
  output logic               match_o,
  output logic [CNT_W-1:0]   match_count_o,
  output logic               armed_o
);

  import seq_det_pkg::*;

  state_t             state_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;
  logic               overlap_q;
  logic [MAX_LEN-2:0] hist_q;
  logic               match_q;
  logic               cfg_err_q;

  logic               cfg_acc_w;
  logic               len_bad_w;
  logic               cfg_ok_w;
  logic               cfg_bad_w;
  logic               shift_w;
  logic [MAX_LEN-1:0] nh_w;
  logic [MAX_LEN-1:0] mask_w;
  logic               fill_full_w;
  logic               hit_w;
  logic [LEN_W-1:0]   fill_inc_w;

  assign cfg_ready_o = ~rst;
  assign cfg_acc_w   = cfg_valid_i & cfg_ready_o;
  assign len_bad_w   = (cfg_len_i == '0) || (32'(cfg_len_i) > 32'(MAX_LEN));
  assign cfg_ok_w    = cfg_acc_w & ~len_bad_w;
  assign cfg_bad_w   = cfg_acc_w & len_bad_w;

  // A bit arriving with an accepted reload is dropped rather than shifted.
  assign shift_w     = (state_q == ST_RUN) & in_valid_i & ~clear_i & ~cfg_ok_w;

  assign nh_w        = {hist_q, in_bit_i};
  assign mask_w      = MAX_LEN'(len_mask(32'(len_q)));
  assign fill_full_w = (32'(fill_q) + 32'd1) >= 32'(len_q);
  assign hit_w       = shift_w & fill_full_w & ((nh_w & mask_w) == (pattern_q & mask_w));
  assign fill_inc_w  = (32'(fill_q) >= 32'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_bad_w;
      match_q   <= hit_w;
      if (cfg_ok_w) begin
        state_q   <= ST_RUN;
        pattern_q <= cfg_pattern_i;
        len_q     <= cfg_len_i;
        overlap_q <= cfg_overlap_i;
        hist_q    <= '0;
        fill_q    <= '0;
      end else if (clear_i) begin
        hist_q <= '0;
        fill_q <= '0;
      end else if (shift_w) begin
        hist_q <= nh_w[MAX_LEN-2:0];
        fill_q <= (hit_w && !overlap_q) ? '0 : fill_inc_w;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clear_i),
    .inc_i (hit_w),
    .cnt_o (match_count_o)
  );

  assign match_o   = match_q;
  assign cfg_err_o = cfg_err_q;
  assign armed_o   = (state_q == ST_RUN);

endmodule

`default_nettype wire
